pg_block: RTL and testbench
===========================

Name: pg_block

Overview:
- Registered 4-bit propagate/generate stage for the front end of the 4-bit carry-lookahead adder.
- Per bit i (1..4): computes p_i and g_i from operand bits a_i and b_i, then registers them.
- Feeds the carry-lookahead and sum stages.
- Index 1 is the LSB; index 4 is the MSB.

Parameters:
- PROP_XOR, 1, propagate function select: 1 gives p_i = a_i XOR b_i; 0 gives p_i = a_i OR b_i (carry-only use).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand bits valid this cycle; captured only when high
- a1  input  1  operand A bit 0 (LSB)
- a2  input  1  operand A bit 1
- a3  input  1  operand A bit 2
- a4  input  1  operand A bit 3 (MSB)
- b1  input  1  operand B bit 0 (LSB)
- b2  input  1  operand B bit 1
- b3  input  1  operand B bit 2
- b4  input  1  operand B bit 3 (MSB)
- p1..p4  output  1 each  registered propagate, bit i
- g1..g4  output  1 each  registered generate, bit i
- out_valid  output  1  high for exactly the cycle after an accepted input

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- While rst_n is low: p1..p4, g1..g4 and out_valid are 0, regardless of clk and inputs.
- Deassertion of rst_n takes effect at the next rising edge of clk.
- On a rising edge with in_valid = 1:
  - g_i <= a_i AND b_i.
  - p_i <= a_i XOR b_i when PROP_XOR = 1; p_i <= a_i OR b_i when PROP_XOR = 0.
  - out_valid <= 1.
- On a rising edge with in_valid = 0:
  - p/g registers hold their previous values.
  - out_valid <= 0.
- Latency is 1 cycle; throughput is one operand pair per cycle. No backpressure.
- Invariant with PROP_XOR = 1: p_i and g_i are never both 1.
- Invariant with PROP_XOR = 0: g_i = 1 implies p_i = 1.
- Reset asserted mid-stream: outputs clear immediately and the in-flight result is discarded. The first valid capture after reset yields out_valid on the following cycle.
- No X propagation from unused paths. All 256 input combinations are legal.

Optional Feature:
- Macro: PG_GROUP_EN.
- Defined: two extra registered outputs, gp (1 bit) and gg (1 bit). Both update under the same in_valid and reset rules as p/g, so they are aligned with p1..p4.
  - gp = p4&p3&p2&p1.
  - gg = g4 | p4&g3 | p4&p3&g2 | p4&p3&p2&g1.
  - Both are computed from the newly captured p/g values, not the stale ones. Both reset to 0.
- Undefined: ports gp and gg and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 with a1..a4 = 1111, b1..b4 = 1111, in_valid = 1, toggling clk -> all p, g and out_valid = 0. Assert rst_n mid-cycle -> outputs clear without waiting for a clock edge.
- Exhaustive (PROP_XOR = 1): drive all 256 {a1,a2,a3,a4,b1,b2,b3,b4} values with in_valid = 1, one per cycle -> one cycle later, each p_i = a_i^b_i, g_i = a_i&b_i, and out_valid = 1 on every cycle.
- Spot check: a = 1,0,1,1 (a1..a4), b = 1,1,0,1 -> p1..p4 = 0,1,1,0 and g1..g4 = 1,0,0,1.
- Hold: capture a = 1111, b = 0101, then drop in_valid for 3 cycles while inputs change to 0000 -> p1..p4 = 1,0,1,0 and g1..g4 = 0,1,0,1 are held; out_valid = 0 on those cycles.
- PROP_XOR = 0: a = 1100, b = 1010 (a1..a4, b1..b4) -> p1..p4 = 1,1,1,0 and g1..g4 = 1,0,0,0.
- PG_GROUP_EN with PROP_XOR = 1:
  - a = 1111, b = 0000 -> gp = 1, gg = 0.
  - a = 0001, b = 0001 (only a4, b4 set) -> gg = 1, gp = 0.
  - a = 1000, b = 1000 with p2..p4 = 1 via a = 1000, b = 1111 -> gp = 0, gg = 1 (g1 = 1, p2 = p3 = p4 = 1).

Source files
------------

// File: rtl/pg_block.sv
// Registered 4-bit propagate/generate front end for a carry-lookahead adder.
// Optional group propagate/generate outputs gp/gg under macro PG_GROUP_EN.
module pg_block #(
    parameter bit PROP_XOR = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic a4,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic b4,
    output logic p1,
    output logic p2,
    output logic p3,
    output logic p4,
    output logic g1,
    output logic g2,
    output logic g3,
    output logic g4,
    output logic out_valid
`ifdef PG_GROUP_EN
    ,
    output logic gp,
    output logic gg
`endif
);

    logic [3:0] a_vec;
    logic [3:0] b_vec;
    logic [3:0] p_d;
    logic [3:0] g_d;
    logic [3:0] p_q;
    logic [3:0] g_q;
    logic       vld_q;

    // Bit 0 of each vector is index 1 (LSB).
    assign a_vec = {a4, a3, a2, a1};
    assign b_vec = {b4, b3, b2, b1};

    assign g_d = a_vec & b_vec;
    assign p_d = PROP_XOR ? (a_vec ^ b_vec) : (a_vec | b_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= 4'b0000;
            g_q   <= 4'b0000;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                p_q <= p_d;
                g_q <= g_d;
            end
        end
    end

    assign {p4, p3, p2, p1} = p_q;
    assign {g4, g3, g2, g1} = g_q;
    assign out_valid = vld_q;

`ifdef PG_GROUP_EN
    logic gp_d;
    logic gg_d;
    logic gp_q;
    logic gg_q;

    // Built from the incoming p/g so the group terms line up with p1..p4.
    assign gp_d = &p_d;
    assign gg_d = g_d[3]
                | (p_d[3] & g_d[2])
                | (p_d[3] & p_d[2] & g_d[1])
                | (p_d[3] & p_d[2] & p_d[1] & g_d[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gp_q <= 1'b0;
            gg_q <= 1'b0;
        end else if (in_valid) begin
            gp_q <= gp_d;
            gg_q <= gg_d;
        end
    end

    assign gp = gp_q;
    assign gg = gg_q;
`endif

endmodule

// File: tb/tb_pg_block.sv
// Directed self-checking bench for pg_block (XOR and OR propagate builds).
// Group outputs are checked when PG_GROUP_EN is defined.
module tb_pg_block;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic a1, a2, a3, a4, b1, b2, b3, b4;
    logic p1, p2, p3, p4, g1, g2, g3, g4, out_valid;
    logic q1, q2, q3, q4, h1, h2, h3, h4, ov_or;
`ifdef PG_GROUP_EN
    logic gp, gg, gp_or, gg_or;
`endif

    int tests = 0;
    int fails = 0;

    logic [3:0] pv, gv, pov, gov;
    assign pv  = {p1, p2, p3, p4};
    assign gv  = {g1, g2, g3, g4};
    assign pov = {q1, q2, q3, q4};
    assign gov = {h1, h2, h3, h4};

    always #5 clk = ~clk;

    pg_block #(.PROP_XOR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4),
        .g1(g1), .g2(g2), .g3(g3), .g4(g4),
        .out_valid(out_valid)
`ifdef PG_GROUP_EN
        , .gp(gp), .gg(gg)
`endif
    );

    pg_block #(.PROP_XOR(1'b0)) dut_or (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4),
        .p1(q1), .p2(q2), .p3(q3), .p4(q4),
        .g1(h1), .g2(h2), .g3(h3), .g4(h4),
        .out_valid(ov_or)
`ifdef PG_GROUP_EN
        , .gp(gp_or), .gg(gg_or)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // a/b given as {x1,x2,x3,x4}
    task automatic set_in(input logic [3:0] a, input logic [3:0] b,
                          input logic v);
        {a1, a2, a3, a4} = a;
        {b1, b2, b3, b4} = b;
        in_valid = v;
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b,
                         input logic v);
        @(negedge clk);
        set_in(a, b, v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ea, eb;
        rst_n = 1'b0;
        set_in(4'b1111, 4'b1111, 1'b1);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", {pv, gv[3:1], out_valid}, 8'h00);
        end
        check("reset_hold_or", {pov, gov[3:1], ov_or}, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1011, 4'b1101, 1'b1);
        check("spot_p", {4'b0, pv}, 8'b0110);
        check("spot_g", {4'b0, gv}, 8'b1001);
        check("spot_valid", {7'b0, out_valid}, 8'h01);

        // Asynchronous clear in the middle of the cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clr", {pv, gv[3:1], out_valid}, 8'h00);
        check("async_clr_g1", {7'b0, g1}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", {7'b0, out_valid}, 8'h00);
        apply(4'b1011, 4'b1101, 1'b1);
        check("first_cap_valid", {7'b0, out_valid}, 8'h01);

        for (int v = 0; v < 256; v++) begin
            ea = v[7:4];
            eb = v[3:0];
            apply(ea, eb, 1'b1);
            check("exh_p", {4'b0, pv}, {4'b0, ea ^ eb});
            check("exh_g", {4'b0, gv}, {4'b0, ea & eb});
            check("exh_valid", {7'b0, out_valid}, 8'h01);
            check("exh_or_p", {4'b0, pov}, {4'b0, ea | eb});
            check("exh_or_g", {4'b0, gov}, {4'b0, ea & eb});
            check("inv_xor", {4'b0, pv & gv}, 8'h00);
            check("inv_or", {4'b0, gov & ~pov}, 8'h00);
        end

        apply(4'b1111, 4'b0101, 1'b1);
        check("hold_cap_p", {4'b0, pv}, 8'b1010);
        for (int i = 0; i < 3; i++) begin
            apply(4'b0000, 4'b0000, 1'b0);
            check("hold_p", {4'b0, pv}, 8'b1010);
            check("hold_g", {4'b0, gv}, 8'b0101);
            check("hold_valid", {7'b0, out_valid}, 8'h00);
        end

        apply(4'b1100, 4'b1010, 1'b1);
        check("or_p", {4'b0, pov}, 8'b1110);
        check("or_g", {4'b0, gov}, 8'b1000);
        check("or_valid", {7'b0, ov_or}, 8'h01);

`ifdef PG_GROUP_EN
        apply(4'b1111, 4'b0000, 1'b1);
        check("grp_all_p", {6'b0, gp, gg}, 8'b10);
        apply(4'b0001, 4'b0001, 1'b1);
        check("grp_msb_g", {6'b0, gp, gg}, 8'b01);
        apply(4'b1000, 4'b1111, 1'b1);
        check("grp_ripple", {6'b0, gp, gg}, 8'b01);
        apply(4'b0000, 4'b0000, 1'b0);
        check("grp_hold", {6'b0, gp, gg}, 8'b01);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
